// File: rtl/cycle_sequencer_if.sv
// Handshake/bus bundle for cycle_sequencer: request controls in, phase/timing status out.
interface cycle_sequencer_if #(
  parameter int unsigned CNT_W = 3
) ();
  logic             start;
  logic             stall;
  logic             abort;
  logic [CNT_W-1:0] addr_cycles;
  logic [CNT_W-1:0] op_cycles;
  logic [CNT_W-1:0] time_out;
  logic [1:0]       phase;
  logic             busy;
  logic             last_cycle;
  logic             done;

  modport master (
    output start, stall, abort, addr_cycles, op_cycles,
    input  time_out, phase, busy, last_cycle, done
  );

  modport slave (
    input  start, stall, abort, addr_cycles, op_cycles,
    output time_out, phase, busy, last_cycle, done
  );
endinterface

// File: rtl/cycle_sequencer.sv
// Two-phase (addressing then operation) cycle sequencer with stall, abort and
// back-to-back restart on the final operation cycle.
module cycle_sequencer #(
  parameter int unsigned CNT_W = 3
) (
  input logic               clk,
  input logic               rst,
  cycle_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAddr = 2'b01,
    StOp   = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] time_q, time_d;
  logic [CNT_W-1:0] op_q, op_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      time_q  <= '0;
      op_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    op_d    = op_q;
    done_d  = 1'b0;
    if (bus.abort) begin
      state_d = StIdle;
      time_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          // Start is accepted in idle even while stalled.
          if (bus.start) begin
            state_d = StAddr;
            time_d  = bus.addr_cycles;
            op_d    = bus.op_cycles;
          end else begin
            time_d = '0;
          end
        end
        StAddr: begin
          if (!bus.stall) begin
            if (time_q != '0) begin
              time_d = time_q - CNT_W'(1);
            end else begin
              state_d = StOp;
              time_d  = op_q;
            end
          end
        end
        StOp: begin
          if (!bus.stall) begin
            if (time_q != '0) begin
              time_d = time_q - CNT_W'(1);
            end else begin
              done_d = 1'b1;
              // Chain straight into the next sequence with no idle gap.
              if (bus.start) begin
                state_d = StAddr;
                time_d  = bus.addr_cycles;
                op_d    = bus.op_cycles;
              end else begin
                state_d = StIdle;
                time_d  = '0;
              end
            end
          end
        end
        default: begin
          state_d = StIdle;
          time_d  = '0;
        end
      endcase
    end
  end

  assign bus.time_out   = time_q;
  assign bus.phase      = state_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.last_cycle = (state_q == StOp) && (time_q == '0);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed table-driven bench for cycle_sequencer plus hand-written reset and restart sequences.
module tb_cycle_sequencer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  cycle_sequencer_if #(.CNT_W(3)) bus ();

  cycle_sequencer #(.CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stall;
    logic       abort;
    logic [2:0] addr;
    logic [2:0] op;
    logic [1:0] ph;
    logic [2:0] t;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic st, input logic ab, input logic [2:0] a,
                     input logic [2:0] o, input logic [1:0] ph, input logic [2:0] t,
                     input logic d);
    vec_t v;
    v.start = s; v.stall = st; v.abort = ab; v.addr = a; v.op = o;
    v.ph = ph; v.t = t; v.done = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input logic s, input logic st, input logic ab, input logic [2:0] a,
                       input logic [2:0] o);
    bus.start = s; bus.stall = st; bus.abort = ab; bus.addr_cycles = a; bus.op_cycles = o;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic [1:0] ph, input logic [2:0] t,
                           input logic d);
    check("phase", idx, 32'(bus.phase), 32'(ph));
    check("time_out", idx, 32'(bus.time_out), 32'(t));
    check("busy", idx, 32'(bus.busy), 32'(ph != 2'b00));
    check("last_cycle", idx, 32'(bus.last_cycle), 32'((ph == 2'b10) && (t == 3'd0)));
    check("done", idx, 32'(bus.done), 32'(d));
  endtask

  initial begin
    int  busy_cnt;
    logic done_seen;
    n_tests = 0;
    n_fail  = 0;
    bus.start = 1'b0; bus.stall = 1'b0; bus.abort = 1'b0;
    bus.addr_cycles = '0; bus.op_cycles = '0;

    // start: st stall ab addr op | phase t done
    // addr=2 op=1; op changed after acceptance must be ignored
    add(1, 0, 0, 3'd2, 3'd1, 2'b01, 3'd2, 0);
    add(0, 0, 0, 3'd2, 3'd5, 2'b01, 3'd1, 0);
    add(0, 0, 0, 3'd2, 3'd5, 2'b01, 3'd0, 0);
    add(0, 0, 0, 3'd2, 3'd5, 2'b10, 3'd1, 0);
    add(0, 0, 0, 3'd2, 3'd5, 2'b10, 3'd0, 0);
    add(0, 0, 0, 3'd2, 3'd5, 2'b00, 3'd0, 1);
    add(0, 0, 0, 3'd2, 3'd5, 2'b00, 3'd0, 0);
    // addr=0 op=0
    add(1, 0, 0, 3'd0, 3'd0, 2'b01, 3'd0, 0);
    add(0, 0, 0, 3'd0, 3'd0, 2'b10, 3'd0, 0);
    add(0, 0, 0, 3'd0, 3'd0, 2'b00, 3'd0, 1);
    // back-to-back: start ignored in ADDR, accepted on last_cycle
    add(1, 0, 0, 3'd0, 3'd0, 2'b01, 3'd0, 0);
    add(1, 0, 0, 3'd1, 3'd0, 2'b10, 3'd0, 0);
    add(1, 0, 0, 3'd1, 3'd0, 2'b01, 3'd1, 1);
    add(0, 0, 0, 3'd1, 3'd0, 2'b01, 3'd0, 0);
    add(0, 0, 0, 3'd1, 3'd0, 2'b10, 3'd0, 0);
    add(0, 0, 0, 3'd1, 3'd0, 2'b00, 3'd0, 1);
    // addr=3 op=0 with 3 stall cycles at time_out=1
    add(1, 0, 0, 3'd3, 3'd0, 2'b01, 3'd3, 0);
    add(0, 0, 0, 3'd3, 3'd0, 2'b01, 3'd2, 0);
    add(0, 0, 0, 3'd3, 3'd0, 2'b01, 3'd1, 0);
    add(0, 1, 0, 3'd3, 3'd0, 2'b01, 3'd1, 0);
    add(0, 1, 0, 3'd3, 3'd0, 2'b01, 3'd1, 0);
    add(0, 1, 0, 3'd3, 3'd0, 2'b01, 3'd1, 0);
    add(0, 0, 0, 3'd3, 3'd0, 2'b01, 3'd0, 0);
    add(0, 0, 0, 3'd3, 3'd0, 2'b10, 3'd0, 0);
    add(0, 0, 0, 3'd3, 3'd0, 2'b00, 3'd0, 1);
    // start accepted in idle despite stall; abort in OP with start; restart; abort beats stall
    add(1, 1, 0, 3'd0, 3'd3, 2'b01, 3'd0, 0);
    add(0, 0, 0, 3'd0, 3'd3, 2'b10, 3'd3, 0);
    add(0, 0, 0, 3'd0, 3'd3, 2'b10, 3'd2, 0);
    add(1, 0, 1, 3'd0, 3'd3, 2'b00, 3'd0, 0);
    add(1, 0, 0, 3'd2, 3'd0, 2'b01, 3'd2, 0);
    add(0, 1, 1, 3'd2, 3'd0, 2'b00, 3'd0, 0);
    add(0, 0, 0, 3'd2, 3'd0, 2'b00, 3'd0, 0);
    // stall on the last OP cycle suppresses done until released
    add(1, 0, 0, 3'd0, 3'd0, 2'b01, 3'd0, 0);
    add(0, 0, 0, 3'd0, 3'd0, 2'b10, 3'd0, 0);
    add(0, 1, 0, 3'd0, 3'd0, 2'b10, 3'd0, 0);
    add(0, 0, 0, 3'd0, 3'd0, 2'b00, 3'd0, 1);

    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_all(-1, 2'b00, 3'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 check_all(-2, 2'b00, 3'd0, 1'b0);

    foreach (vecs[i]) begin
      apply(vecs[i].start, vecs[i].stall, vecs[i].abort, vecs[i].addr, vecs[i].op);
      check_all(i, vecs[i].ph, vecs[i].t, vecs[i].done);
    end

    // addr=7 op=7, reset asserted mid-OP
    done_seen = 1'b0;
    apply(1, 0, 0, 3'd7, 3'd7);
    check_all(100, 2'b01, 3'd7, 1'b0);
    for (int k = 0; k < 10; k++) begin
      apply(0, 0, 0, 3'd7, 3'd7);
      if (bus.done) done_seen = 1'b1;
    end
    check_all(101, 2'b10, 3'd5, 1'b0);
    #3 rst = 1'b0;
    #1 check_all(102, 2'b00, 3'd0, 1'b0);
    @(posedge clk);
    #1 check_all(103, 2'b00, 3'd0, 1'b0);
    if (bus.done) done_seen = 1'b1;
    rst = 1'b1;
    check("no_done_on_reset", 104, 32'(done_seen), 32'd0);

    // fresh start addr=1 op=1 after release
    apply(1, 0, 0, 3'd1, 3'd1);
    check_all(105, 2'b01, 3'd1, 1'b0);
    busy_cnt  = 1;
    done_seen = 1'b0;
    for (int k = 0; k < 20 && !done_seen; k++) begin
      apply(0, 0, 0, 3'd0, 3'd0);
      if (bus.busy) busy_cnt++;
      if (bus.done) done_seen = 1'b1;
    end
    check("done_after_reset", 106, 32'(done_seen), 32'd1);
    check("busy_cycles", 106, 32'(busy_cnt), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001: Parameter CNT_W, default 3, sets the width of the cycle-count codes and of time_out.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst  input  1  reset, asynchronous, active-low.
REQ-004: start  input  1  request to begin a new addressing+operation sequence.
REQ-005: stall  input  1  freeze the sequence while high; no state, count or output register changes.
REQ-006: abort  input  1  synchronous cancel of any in-progress sequence.
REQ-007: addr_cycles  input  CNT_W  addressing-phase code; the phase lasts addr_cycles+1 unstalled cycles.
REQ-008: op_cycles  input  CNT_W  operation-phase code; the phase lasts op_cycles+1 unstalled cycles.
REQ-009: time_out  output  CNT_W  remaining count in the current phase (registered).
REQ-010: phase  output  2  registered state: 00 IDLE, 01 ADDR, 10 OP; 11 never driven.
REQ-011: busy  output  1  high when phase != IDLE (combinational from state).
REQ-012: last_cycle  output  1  high when phase==OP and time_out==0 (combinational).
REQ-013: done  output  1  registered one-cycle pulse marking completion of an OP phase.

Function
REQ-014: The FSM SHALL have states IDLE, ADDR and OP, plus an internal op_reg of CNT_W bits.
REQ-015: In IDLE with start=1 and abort=0, the next edge SHALL set time_out<=addr_cycles, op_reg<=op_cycles and state<=ADDR, regardless of stall.
REQ-016: op_cycles SHALL be sampled only at start acceptance; later changes are ignored for that sequence.
REQ-017: In ADDR with stall=0, time_out SHALL decrement by 1 when nonzero; when it is 0, time_out<=op_reg and state<=OP.
REQ-018: In OP with stall=0, time_out SHALL decrement by 1 when nonzero; when it is 0, state<=IDLE, time_out<=0 and done<=1 for exactly one cycle.
REQ-019: With last_cycle=1, stall=0 and start=1, the sequencer SHALL go directly to ADDR, loading addr_cycles and op_cycles; done still pulses; there are no IDLE cycles.
REQ-020: start SHALL be ignored in ADDR, and in OP when last_cycle=0.
REQ-021: With stall=1 in ADDR or OP, state, time_out and op_reg SHALL hold and done SHALL be 0.
REQ-022: abort=1 SHALL have priority over start and stall: the next edge sets state<=IDLE, time_out<=0 and done<=0, with no done pulse.
REQ-023: In IDLE with no start, time_out SHALL stay 0.
REQ-024: Arithmetic SHALL be unsigned CNT_W bits; decrement occurs only from nonzero values, so time_out never wraps.
REQ-025: The total busy cycles, unstalled, SHALL equal addr_cycles+op_cycles+2.

Reset
REQ-026: rst=0 SHALL immediately force state=IDLE, time_out=0, op_reg=0 and done=0, so busy=0 and last_cycle=0.
REQ-027: Reset asserted mid-sequence SHALL abandon the sequence with no done pulse; the first start after release begins cleanly.

Verification
REQ-028: CNT_W=3, start with addr=2, op=1 -> time_out 2,1,0 (ADDR) then 1,0 (OP); busy for 5 cycles; done high on the 6th cycle only.
REQ-029: addr=0, op=0 -> one ADDR cycle, one OP cycle with last_cycle=1, done on the next cycle.
REQ-030: addr=3, op=0; stall high for 3 cycles while time_out=1 in ADDR -> time_out holds at 1, then resumes 0 and enters OP; busy for 8 cycles total.
REQ-031: start held high with last_cycle=1, new addr=1 -> next cycle phase=ADDR with time_out=1; done pulses the same cycle; busy never drops.
REQ-032: abort in OP at time_out=2, with start=1 simultaneously -> IDLE, time_out=0, no done; a start in the following cycle is accepted.
REQ-033: addr=7, op=7, then rst low during OP -> immediate IDLE with outputs 0 and no wrap; after release, a fresh start with addr=1, op=1 completes in 4 busy cycles.
